// File: rtl/dir_access_sched.sv
// Directory SRAM access scheduler: core requests queue in a small FIFO, coherence
// requests win arbitration with a starvation guard. Optional perf counters: DIR_ACCESS_SCHED_PERF_EN.
module dir_access_sched #(
  parameter int unsigned NumWays       = 4,
  parameter int unsigned DirAddrWidth  = 7,
  parameter int unsigned DirEntryWidth = 24,
  parameter int unsigned PendDepth     = 2,
  parameter int unsigned StarveMax     = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             core_req_valid_i,
  output logic                             core_req_ready_o,
  input  logic [DirAddrWidth-1:0]          core_addr_i,
  input  logic [NumWays-1:0]               core_cs_i,
  input  logic [NumWays-1:0]               core_we_i,
  input  logic [NumWays*DirEntryWidth-1:0] core_wentry_i,
  input  logic                             coh_req_valid_i,
  output logic                             coh_req_ready_o,
  input  logic [DirAddrWidth-1:0]          coh_addr_i,
  input  logic [NumWays-1:0]               coh_cs_i,
  input  logic [NumWays-1:0]               coh_we_i,
  input  logic [NumWays*DirEntryWidth-1:0] coh_wentry_i,
  output logic [DirAddrWidth-1:0]          dir_addr_o,
  output logic [NumWays-1:0]               dir_cs_o,
  output logic [NumWays-1:0]               dir_we_o,
  output logic [NumWays*DirEntryWidth-1:0] dir_wentry_o,
  output logic                             dir_src_o
`ifdef DIR_ACCESS_SCHED_PERF_EN
  ,
  output logic [31:0]                      perf_coh_issue_o,
  output logic [31:0]                      perf_core_stall_o
`endif
);

  localparam int unsigned PtrW = (PendDepth > 1) ? $clog2(PendDepth) : 1;
  localparam int unsigned EntW = NumWays * DirEntryWidth;

  typedef struct packed {
    logic [DirAddrWidth-1:0] addr;
    logic [NumWays-1:0]      cs;
    logic [NumWays-1:0]      we;
    logic [EntW-1:0]         wentry;
  } req_t;

  req_t            r_fifo [PendDepth];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW:0]   r_count;
  logic [3:0]      r_starve;

  logic w_empty;
  logic w_full;
  logic w_force_core;
  logic w_coh_issue;
  logic w_core_issue;
  logic w_push;
  req_t w_head;

  always_comb begin
    w_empty      = (r_count == '0);
    w_full       = (r_count == (PtrW+1)'(PendDepth));
    w_force_core = !w_empty && (r_starve == 4'(StarveMax));
    w_coh_issue  = coh_req_valid_i && !w_force_core;
    // Pop only from entries present before this cycle, so a push is never issued same-cycle.
    w_core_issue = !w_coh_issue && !w_empty;
    w_push       = core_req_valid_i && !w_full;
    w_head       = r_fifo[r_rd_ptr];
  end

  assign core_req_ready_o = !w_full;
  assign coh_req_ready_o  = !w_force_core;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= '{addr: core_addr_i, cs: core_cs_i, we: core_we_i, wentry: core_wentry_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_core_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_core_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve <= '0;
    end else if (w_coh_issue && !w_empty) begin
      r_starve <= r_starve + 1'b1;
    end else begin
      r_starve <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_addr_o   <= '0;
      dir_cs_o     <= '0;
      dir_we_o     <= '0;
      dir_wentry_o <= '0;
      dir_src_o    <= 1'b0;
    end else if (w_coh_issue) begin
      dir_addr_o   <= coh_addr_i;
      dir_cs_o     <= coh_cs_i;
      dir_we_o     <= coh_we_i;
      dir_wentry_o <= coh_wentry_i;
      dir_src_o    <= 1'b1;
    end else if (w_core_issue) begin
      dir_addr_o   <= w_head.addr;
      dir_cs_o     <= w_head.cs;
      dir_we_o     <= w_head.we;
      dir_wentry_o <= w_head.wentry;
      dir_src_o    <= 1'b0;
    end else begin
      dir_cs_o <= '0;
      dir_we_o <= '0;
    end
  end

`ifdef DIR_ACCESS_SCHED_PERF_EN
  logic [31:0] r_perf_coh;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_coh   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_coh_issue && (r_perf_coh != '1)) begin
        r_perf_coh <= r_perf_coh + 1'b1;
      end
      if (core_req_valid_i && w_full && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
    end
  end

  assign perf_coh_issue_o  = r_perf_coh;
  assign perf_core_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_dir_access_sched.sv
// Randomized bench for dir_access_sched against a queue-based reference model.
// Perf counter checks are included when DIR_ACCESS_SCHED_PERF_EN is defined.
module tb_dir_access_sched;

  localparam int unsigned NW  = 4;
  localparam int unsigned AW  = 7;
  localparam int unsigned EW  = 24;
  localparam int unsigned PD  = 2;
  localparam int unsigned SM  = 4;
  localparam int unsigned ENT = NW * EW;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           core_req_valid_i;
  logic           core_req_ready_o;
  logic [AW-1:0]  core_addr_i;
  logic [NW-1:0]  core_cs_i;
  logic [NW-1:0]  core_we_i;
  logic [ENT-1:0] core_wentry_i;
  logic           coh_req_valid_i;
  logic           coh_req_ready_o;
  logic [AW-1:0]  coh_addr_i;
  logic [NW-1:0]  coh_cs_i;
  logic [NW-1:0]  coh_we_i;
  logic [ENT-1:0] coh_wentry_i;
  logic [AW-1:0]  dir_addr_o;
  logic [NW-1:0]  dir_cs_o;
  logic [NW-1:0]  dir_we_o;
  logic [ENT-1:0] dir_wentry_o;
  logic           dir_src_o;
`ifdef DIR_ACCESS_SCHED_PERF_EN
  logic [31:0]    perf_coh_issue_o;
  logic [31:0]    perf_core_stall_o;
`endif

  dir_access_sched #(
    .NumWays      (NW),
    .DirAddrWidth (AW),
    .DirEntryWidth(EW),
    .PendDepth    (PD),
    .StarveMax    (SM)
  ) u_dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .core_req_valid_i(core_req_valid_i),
    .core_req_ready_o(core_req_ready_o),
    .core_addr_i     (core_addr_i),
    .core_cs_i       (core_cs_i),
    .core_we_i       (core_we_i),
    .core_wentry_i   (core_wentry_i),
    .coh_req_valid_i (coh_req_valid_i),
    .coh_req_ready_o (coh_req_ready_o),
    .coh_addr_i      (coh_addr_i),
    .coh_cs_i        (coh_cs_i),
    .coh_we_i        (coh_we_i),
    .coh_wentry_i    (coh_wentry_i),
    .dir_addr_o      (dir_addr_o),
    .dir_cs_o        (dir_cs_o),
    .dir_we_o        (dir_we_o),
    .dir_wentry_o    (dir_wentry_o),
    .dir_src_o       (dir_src_o)
`ifdef DIR_ACCESS_SCHED_PERF_EN
    ,
    .perf_coh_issue_o (perf_coh_issue_o),
    .perf_core_stall_o(perf_core_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [NW-1:0]  cs;
    logic [NW-1:0]  we;
    logic [ENT-1:0] wentry;
  } mreq_t;

  // Reference model: pending core requests, the issued access, and the overtake tally.
  mreq_t          m_q[$];
  int unsigned    m_overtakes;
  logic [AW-1:0]  m_addr;
  logic [NW-1:0]  m_cs;
  logic [NW-1:0]  m_we;
  logic [ENT-1:0] m_wentry;
  logic           m_src;
  int unsigned    m_perf_coh;
  int unsigned    m_perf_stall;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_overtakes  = 0;
    m_addr       = '0;
    m_cs         = '0;
    m_we         = '0;
    m_wentry     = '0;
    m_src        = 1'b0;
    m_perf_coh   = 0;
    m_perf_stall = 0;
  endtask

  task automatic check_issue();
    check("dir_addr", 128'(dir_addr_o), 128'(m_addr));
    check("dir_cs", 128'(dir_cs_o), 128'(m_cs));
    check("dir_we", 128'(dir_we_o), 128'(m_we));
    check("dir_wentry", 128'(dir_wentry_o), 128'(m_wentry));
    check("dir_src", 128'(dir_src_o), 128'(m_src));
`ifdef DIR_ACCESS_SCHED_PERF_EN
    check("perf_coh", 128'(perf_coh_issue_o), 128'(m_perf_coh));
    check("perf_stall", 128'(perf_core_stall_o), 128'(m_perf_stall));
`endif
  endtask

  // One clock cycle: check last issue, apply inputs, check readies, advance model.
  task automatic cycle(input logic cv, input mreq_t creq, input logic hv, input mreq_t hreq);
    bit full;
    bit starving;
    @(negedge clk_i);
    check_issue();
    core_req_valid_i = cv;
    core_addr_i      = creq.addr;
    core_cs_i        = creq.cs;
    core_we_i        = creq.we;
    core_wentry_i    = creq.wentry;
    coh_req_valid_i  = hv;
    coh_addr_i       = hreq.addr;
    coh_cs_i         = hreq.cs;
    coh_we_i         = hreq.we;
    coh_wentry_i     = hreq.wentry;
    #1;
    full     = (m_q.size() == PD);
    starving = (m_q.size() != 0) && (m_overtakes == SM);
    check("core_ready", 128'(core_req_ready_o), 128'(!full));
    check("coh_ready", 128'(coh_req_ready_o), 128'(!starving));
    if (cv && full) m_perf_stall++;
    if (hv && !starving) begin
      m_addr = hreq.addr; m_cs = hreq.cs; m_we = hreq.we; m_wentry = hreq.wentry; m_src = 1'b1;
      m_perf_coh++;
      m_overtakes = (m_q.size() != 0) ? m_overtakes + 1 : 0;
    end else if (m_q.size() != 0) begin
      mreq_t h;
      h = m_q.pop_front();
      m_addr = h.addr; m_cs = h.cs; m_we = h.we; m_wentry = h.wentry; m_src = 1'b0;
      m_overtakes = 0;
    end else begin
      m_cs = '0; m_we = '0; m_overtakes = 0;
    end
    if (cv && !full) m_q.push_back(creq);
  endtask

  function automatic mreq_t rnd_req();
    mreq_t r;
    r.addr   = AW'($urandom);
    r.cs     = ($urandom_range(0, 15) == 0) ? '0 : NW'($urandom);
    r.we     = NW'($urandom) & r.cs;
    r.wentry = {$urandom, $urandom, $urandom};
    return r;
  endfunction

  function automatic mreq_t mk(input int unsigned a, input int unsigned cs,
                               input int unsigned we, input logic [ENT-1:0] w);
    mreq_t r;
    r.addr = AW'(a); r.cs = NW'(cs); r.we = NW'(we); r.wentry = w;
    return r;
  endfunction

  task automatic async_reset();
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    model_clear();
    check("rst_cs", 128'(dir_cs_o), 128'(0));
    check("rst_we", 128'(dir_we_o), 128'(0));
    check("rst_addr", 128'(dir_addr_o), 128'(0));
    check("rst_wentry", 128'(dir_wentry_o), 128'(0));
    check("rst_src", 128'(dir_src_o), 128'(0));
    core_req_valid_i = 1'b0;
    coh_req_valid_i  = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  mreq_t idle_r;
  mreq_t ra, rb, rc, rh;

  initial begin
    idle_r = mk(0, 0, 0, '0);
    rst_ni = 1'b0;
    core_req_valid_i = 1'b0; core_addr_i = '0; core_cs_i = '0; core_we_i = '0; core_wentry_i = '0;
    coh_req_valid_i  = 1'b0; coh_addr_i  = '0; coh_cs_i  = '0; coh_we_i  = '0; coh_wentry_i  = '0;
    model_clear();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Single core read: issued two cycles after acceptance, for one cycle.
    cycle(1'b1, mk('h12, 'b0001, 0, '0), 1'b0, idle_r);
    repeat (3) cycle(1'b0, idle_r, 1'b0, idle_r);

    // Single coherence write to way 2.
    cycle(1'b0, idle_r, 1'b1, mk('h05, 'b0100, 'b0100, ENT'(96'hABCDEF) << (2 * EW)));
    repeat (2) cycle(1'b0, idle_r, 1'b0, idle_r);

    // Saturated coherence with one queued core request: starvation guard.
    cycle(1'b1, mk('h33, 'b1000, 0, '0), 1'b1, rnd_req());
    repeat (8) cycle(1'b0, idle_r, 1'b1, rnd_req());
    repeat (2) cycle(1'b0, idle_r, 1'b0, idle_r);

    // Three back-to-back core requests under saturated coherence; C must wait for a slot.
    ra = mk('h0A, 'b0001, 0, '0);
    rb = mk('h0B, 'b0010, 0, '0);
    rc = mk('h0C, 'b0100, 0, '0);
    cycle(1'b1, ra, 1'b1, rnd_req());
    cycle(1'b1, rb, 1'b1, rnd_req());
    begin
      int unsigned waited = 0;
      while (m_q.size() == PD && waited < 20) begin
        cycle(1'b1, rc, 1'b1, rnd_req());
        waited++;
      end
      check("c_wait_bound", 128'(waited < 20), 128'(1));
    end
    cycle(1'b1, rc, 1'b1, rnd_req());
    repeat (14) cycle(1'b0, idle_r, 1'b1, rnd_req());
    repeat (2) cycle(1'b0, idle_r, 1'b0, idle_r);

    // Reset with two queued entries, then confirm nothing stale issues.
    cycle(1'b1, rnd_req(), 1'b1, rnd_req());
    cycle(1'b1, rnd_req(), 1'b1, rnd_req());
    async_reset();
    repeat (4) cycle(1'b0, idle_r, 1'b0, idle_r);

    // Randomized traffic across load profiles.
    for (int unsigned ph = 0; ph < 4; ph++) begin
      int unsigned pc, ph_coh;
      pc     = (ph == 0) ? 30 : (ph == 1) ? 90 : (ph == 2) ? 60 : 80;
      ph_coh = (ph == 0) ? 30 : (ph == 1) ? 95 : (ph == 2) ? 50 : 100;
      for (int unsigned i = 0; i < 600; i++) begin
        cycle($urandom_range(0, 99) < pc, rnd_req(), $urandom_range(0, 99) < ph_coh, rnd_req());
      end
      if (ph == 2) async_reset();
    end

    // Drain and take one last look at the issue register.
    repeat (12) cycle(1'b0, idle_r, 1'b0, idle_r);
    @(negedge clk_i);
    check_issue();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
